cplx_op_unit: RTL and testbench

Signed fixed-point complex execution unit that receives operation commands from the sequencing controller and returns one result per command. It implements ADD, MUL, ACC and ABS on complex operands for the QFT datapath. Commands arrive on a valid/ready channel. Results leave on a second valid/ready channel. Multiplications share one multiplier pair across two cycles.

---
 rtl/cplx_pkg.sv | 21 ++
 rtl/cplx_sat.sv | 26 ++
 rtl/cplx_op_unit.sv | 173 +++++++++++++++++
 tb/tb_cplx_op_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cplx_pkg.sv
// Shared types and default widths for the complex execution unit.
package cplx_pkg;

    localparam int unsigned W_DEF    = 16;
    localparam int unsigned FRAC_DEF = 14;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_ACC = 2'd2,
        OP_ABS = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cplx_sat.sv
// Saturating narrower: clamps a signed IN_W value into the signed OUT_W range.
module cplx_sat #(
    parameter int unsigned IN_W  = 33,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);

    logic w_fits;

    // Value fits when every bit above the output sign bit matches the input sign.
    assign w_fits = (i_din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){i_din[IN_W-1]}});

    // Pass through when in range, otherwise clamp to the extreme of matching sign.
    always_comb begin
        if (w_fits) begin
            o_dout = i_din[OUT_W-1:0];
        end else if (i_din[IN_W-1]) begin
            o_dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            o_dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/cplx_op_unit.sv
// Signed fixed-point complex execution unit: ADD, MUL (two-phase), ACC, ABS.
module cplx_op_unit
    import cplx_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [1:0]          op_code,
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    input  logic                acc_clr,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [W-1:0] res_re,
    output logic signed [W-1:0] res_im
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned SW = 2 * W + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    op_t                 r_op;
    logic signed [W-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [W-1:0] r_acc_re, r_acc_im;
    logic signed [W-1:0] r_res_re, r_res_im;

    logic signed [W-1:0]  w_x0, w_y0, w_x1, w_y1;
    logic                 w_sub;
    logic signed [PW-1:0] w_m0, w_m1;
    logic signed [SW-1:0] w_psum, w_pscl;
    logic signed [W-1:0]  w_acc_base_re, w_acc_base_im;
    logic signed [SW-1:0] w_re_wide, w_im_wide;
    logic signed [W-1:0]  w_sat_re, w_sat_im;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; MUL takes the extra EXEC2 phase for the imaginary part.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (op_valid) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = (r_op == OP_MUL) ? EXEC2 : DONE;
            EXEC2:   w_state_nxt = DONE;
            DONE:    if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the command once on acceptance; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= OP_ADD;
            r_a_re <= '0;
            r_a_im <= '0;
            r_b_re <= '0;
            r_b_im <= '0;
        end else if ((r_state == IDLE) && op_valid) begin
            r_op   <= op_t'(op_code);
            r_a_re <= a_re;
            r_a_im <= a_im;
            r_b_re <= b_re;
            r_b_im <= b_im;
        end
    end

    // Operand steering for the shared multiplier pair (MUL re, MUL im, ABS).
    always_comb begin
        w_x0  = r_a_re;
        w_y0  = r_b_re;
        w_x1  = r_a_im;
        w_y1  = r_b_im;
        w_sub = 1'b1;
        if (r_state == EXEC2) begin
            w_y0  = r_b_im;
            w_y1  = r_b_re;
            w_sub = 1'b0;
        end else if (r_op == OP_ABS) begin
            w_y0  = r_a_re;
            w_y1  = r_a_im;
            w_sub = 1'b0;
        end
    end

    assign w_m0   = PW'(w_x0) * PW'(w_y0);
    assign w_m1   = PW'(w_x1) * PW'(w_y1);
    assign w_psum = w_sub ? (SW'(w_m0) - SW'(w_m1)) : (SW'(w_m0) + SW'(w_m1));
    assign w_pscl = w_psum >>> FRAC;

    // A clear coinciding with ACC zeroes the base before the add.
    assign w_acc_base_re = acc_clr ? '0 : r_acc_re;
    assign w_acc_base_im = acc_clr ? '0 : r_acc_im;

    // Wide pre-saturation values for the real and imaginary result paths.
    always_comb begin
        w_re_wide = w_pscl;
        w_im_wide = w_pscl;
        case (r_op)
            OP_ADD: begin
                w_re_wide = SW'(r_a_re) + SW'(r_b_re);
                w_im_wide = SW'(r_a_im) + SW'(r_b_im);
            end
            OP_ACC: begin
                w_re_wide = SW'(w_acc_base_re) + SW'(r_a_re);
                w_im_wide = SW'(w_acc_base_im) + SW'(r_a_im);
            end
            default: begin
                w_re_wide = w_pscl;
                w_im_wide = w_pscl;
            end
        endcase
    end

    cplx_sat #(.IN_W(SW), .OUT_W(W)) u_sat_re (
        .i_din  (w_re_wide),
        .o_dout (w_sat_re)
    );

    cplx_sat #(.IN_W(SW), .OUT_W(W)) u_sat_im (
        .i_din  (w_im_wide),
        .o_dout (w_sat_im)
    );

    // Result registers; held unchanged while DONE waits for res_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_re <= '0;
            r_res_im <= '0;
        end else if (r_state == EXEC) begin
            r_res_re <= w_sat_re;
            if (r_op == OP_ABS) begin
                r_res_im <= '0;
            end else if (r_op != OP_MUL) begin
                r_res_im <= w_sat_im;
            end
        end else if (r_state == EXEC2) begin
            r_res_im <= w_sat_im;
        end
    end

    // Saturating accumulator; acc_clr clears it in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if ((r_state == EXEC) && (r_op == OP_ACC)) begin
            r_acc_re <= w_sat_re;
            r_acc_im <= w_sat_im;
        end else if (acc_clr) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end
    end

    assign op_ready  = (r_state == IDLE);
    assign res_valid = (r_state == DONE);
    assign res_re    = r_res_re;
    assign res_im    = r_res_im;

endmodule

// File: tb/tb_cplx_op_unit.sv
// Self-checking bench for cplx_op_unit: directed table, corner sequences, random vs. model.
module tb_cplx_op_unit;

    localparam int unsigned W    = 16;
    localparam int unsigned FRAC = 14;

    localparam int C_ADD = 0;
    localparam int C_MUL = 1;
    localparam int C_ACC = 2;
    localparam int C_ABS = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                op_valid;
    logic                op_ready;
    logic [1:0]          op_code;
    logic signed [W-1:0] a_re, a_im, b_re, b_im;
    logic                acc_clr;
    logic                res_valid;
    logic                res_ready;
    logic signed [W-1:0] res_re, res_im;

    int errors = 0;
    int checks = 0;

    int m_acc_re = 0;
    int m_acc_im = 0;

    typedef struct {
        int op;
        int ar, ai, br, bi;
        bit clr;
        int er, ei, elat;
    } vec_t;

    vec_t tbl[12];

    cplx_op_unit #(.W(W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .acc_clr   (acc_clr),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_re    (res_re),
        .res_im    (res_im)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Floor division by 2^FRAC.
    function automatic longint floor_scale(input longint v);
        longint d;
        longint q;
        d = 64'sd1 <<< FRAC;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    // Reference model of one command; updates the model accumulator.
    function automatic void model(input int op, input int ar, input int ai, input int br,
                                  input int bi, input bit clr,
                                  output int er, output int ei, output int el);
        longint lar, lai, lbr, lbi;
        lar = ar; lai = ai; lbr = br; lbi = bi;
        er = 0; ei = 0; el = 2;
        case (op)
            C_ADD: begin
                er = sat(lar + lbr);
                ei = sat(lai + lbi);
            end
            C_MUL: begin
                er = sat(floor_scale(lar * lbr - lai * lbi));
                ei = sat(floor_scale(lar * lbi + lai * lbr));
                el = 3;
            end
            C_ABS: begin
                er = sat(floor_scale(lar * lar + lai * lai));
                ei = 0;
            end
            default: begin
                if (clr) begin
                    m_acc_re = 0;
                    m_acc_im = 0;
                end
                m_acc_re = sat(longint'(m_acc_re) + lar);
                m_acc_im = sat(longint'(m_acc_im) + lai);
                er = m_acc_re;
                ei = m_acc_im;
            end
        endcase
        if (op != C_ACC && clr) begin
            m_acc_re = 0;
            m_acc_im = 0;
        end
    endfunction

    // Issue one command from a negedge; returns result, latency in edges, busy flag.
    task automatic issue(input int op, input int ar, input int ai, input int br, input int bi,
                         input bit clr, output int rr, output int ri, output int lat,
                         output bit busy_ok);
        int n;
        rr = 0; ri = 0; lat = 0; busy_ok = 1'b1;
        n = 0;
        while (op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (op_ready !== 1'b1) begin
            check("issue_ready_timeout", int'(op_ready), 1);
            return;
        end
        op_code   = 2'(op);
        a_re      = 16'(ar);
        a_im      = 16'(ai);
        b_re      = 16'(br);
        b_im      = 16'(bi);
        op_valid  = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = 2'($urandom);
        a_re     = 16'($urandom);
        a_im     = 16'($urandom);
        b_re     = 16'($urandom);
        b_im     = 16'($urandom);
        acc_clr  = clr;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 10) begin
            if (op_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            acc_clr = 1'b0;
            lat++;
        end
        if (op_ready !== 1'b0) busy_ok = 1'b0;
        acc_clr = 1'b0;
        rr = int'(res_re);
        ri = int'(res_im);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr, ri, lat, n;
        bit bok;
        int op, ar, ai, br, bi, er, ei, el;
        bit clr;

        rst = 1'b1; op_valid = 1'b0; op_code = '0; acc_clr = 1'b0; res_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_op_ready",  int'(op_ready),  1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_re",    int'(res_re),    0);
        check("rst_res_im",    int'(res_im),    0);

        tbl[0]  = '{C_ADD,   8192,  -4096,   4096,   4096, 1'b0,  12288,      0, 2};
        tbl[1]  = '{C_MUL,   8192,   8192,   8192,  -8192, 1'b0,   8192,      0, 3};
        tbl[2]  = '{C_ADD,  30000, -30000,  10000, -10000, 1'b0,  32767, -32768, 2};
        tbl[3]  = '{C_ABS,  16384,  16384,      0,      0, 1'b0,  32767,      0, 2};
        tbl[4]  = '{C_ACC,    100,    200,      0,      0, 1'b0,    100,    200, 2};
        tbl[5]  = '{C_ACC,    100,    200,      0,      0, 1'b0,    200,    400, 2};
        tbl[6]  = '{C_ACC,    100,    200,      0,      0, 1'b0,    300,    600, 2};
        tbl[7]  = '{C_ACC,    100,    200,      0,      0, 1'b1,    100,    200, 2};
        tbl[8]  = '{C_MUL,     -1,      0,      1,      0, 1'b0,     -1,      0, 3};
        tbl[9]  = '{C_MUL, -32768, -32768, -32768,  32767, 1'b0,  32767,      2, 3};
        tbl[10] = '{C_ABS, -20000,  10000,      0,      0, 1'b0,  30517,      0, 2};
        tbl[11] = '{C_ADD, -20000,     -1, -20000,      0, 1'b0, -32768,     -1, 2};

        // Clear the accumulator once before the ACC entries.
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, tbl[i].clr,
                  rr, ri, lat, bok);
            check($sformatf("vec%0d_re", i),   rr,       tbl[i].er);
            check($sformatf("vec%0d_im", i),   ri,       tbl[i].ei);
            check($sformatf("vec%0d_lat", i),  lat,      tbl[i].elat);
            check($sformatf("vec%0d_busy", i), int'(bok), 1);
        end

        // Backpressure: MUL result held for 5 cycles while another command waits.
        res_ready = 1'b0;
        op_code = 2'(C_MUL);
        a_re = 16'(8192); a_im = 16'(8192); b_re = 16'(8192); b_im = -16'sd8192;
        op_valid = 1'b1;
        @(negedge clk);
        op_code = 2'(C_ADD);
        a_re = 16'(1000); a_im = 16'(1000); b_re = 16'(1000); b_im = 16'(1000);
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", int'(res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), int'(res_valid), 1);
            check($sformatf("bp%0d_re", i),    int'(res_re),    8192);
            check($sformatf("bp%0d_im", i),    int'(res_im),    0);
            check($sformatf("bp%0d_ready", i), int'(op_ready),  0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        op_valid  = 1'b0;
        @(negedge clk);
        check("bp_release_ready", int'(op_ready),  1);
        check("bp_release_valid", int'(res_valid), 0);
        @(negedge clk);
        check("bp_no_ghost_valid", int'(res_valid), 0);
        check("bp_no_ghost_ready", int'(op_ready),  1);

        // Reset during EXEC2 of a MUL; acc holds (100,200) beforehand.
        op_code = 2'(C_MUL);
        a_re = 16'(8192); a_im = 16'(8192); b_re = 16'(8192); b_im = 16'(8192);
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        check("rx_exec_ready", int'(op_ready), 0);
        @(negedge clk);
        check("rx_exec2_ready", int'(op_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rx_res_valid", int'(res_valid), 0);
        check("rx_op_ready",  int'(op_ready),  1);
        check("rx_res_re",    int'(res_re),    0);
        check("rx_res_im",    int'(res_im),    0);
        issue(C_ACC, 5, 7, 0, 0, 1'b0, rr, ri, lat, bok);
        check("rx_acc_re", rr, 5);
        check("rx_acc_im", ri, 7);
        issue(C_ADD, 1000, -2000, -3000, 500, 1'b0, rr, ri, lat, bok);
        check("rx_add_re",  rr,  -2000);
        check("rx_add_im",  ri,  -1500);
        check("rx_add_lat", lat, 2);

        // Random commands against the reference model.
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        m_acc_re = 0;
        m_acc_im = 0;
        for (int i = 0; i < 60; i++) begin
            op  = int'($urandom_range(0, 3));
            ar  = int'($urandom_range(0, 65535)) - 32768;
            ai  = int'($urandom_range(0, 65535)) - 32768;
            br  = int'($urandom_range(0, 65535)) - 32768;
            bi  = int'($urandom_range(0, 65535)) - 32768;
            clr = ($urandom_range(0, 3) == 0);
            model(op, ar, ai, br, bi, clr, er, ei, el);
            issue(op, ar, ai, br, bi, clr, rr, ri, lat, bok);
            check($sformatf("rnd%0d_op%0d_re", i, op), rr,  er);
            check($sformatf("rnd%0d_op%0d_im", i, op), ri,  ei);
            check($sformatf("rnd%0d_lat", i),          lat, el);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
